jpeg_rle: RTL

Zigzag scan and run-length encoder for the JPEG accelerator. It sits directly downstream of the quantizer's output memory. Once a quantized 8x8 block is complete, it reads the 64 signed 16-bit coefficients from that memory (two per 32-bit word) in zigzag order. It emits JPEG symbols (run, size, amplitude) over a valid/ready stream for the Huffman stage: one differential DC symbol, then AC symbols with ZRL/EOB handling.

---
 rtl/jpeg_rle_if.sv | 27 ++
 rtl/jpeg_rle.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_rle_if.sv
// Stream and memory bundle between the zigzag/RLE encoder, the quantizer output
// memory and the Huffman stage. The master side is the encoder.
interface jpeg_rle_if;
  logic        start;
  logic        clr_dc;
  logic [4:0]  mem_adr;
  logic [31:0] mem_dat;
  logic        sym_valid;
  logic        sym_ready;
  logic [3:0]  sym_run;
  logic [3:0]  sym_size;
  logic [10:0] sym_amp;
  logic        sym_dc;
  logic        sym_eob;
  logic        busy;
  logic        done;

  modport master (
    input  start, clr_dc, mem_dat, sym_ready,
    output mem_adr, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_eob, busy, done
  );

  modport slave (
    output start, clr_dc, mem_dat, sym_ready,
    input  mem_adr, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_eob, busy, done
  );
endinterface

// File: rtl/jpeg_rle.sv
// Zigzag scan and run-length encoder: reads one quantized 8x8 block from the
// quantizer output memory and emits DC/AC/ZRL/EOB symbols for the Huffman stage.
module jpeg_rle (
  input  logic        clk_i,
  input  logic        rst_i,
  jpeg_rle_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_EVAL, ST_ZRL, ST_EMIT, ST_EOB, ST_DONE
  } state_t;

  localparam logic [5:0] ZZ_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic signed [11:0] sat12(input logic signed [16:0] v);
    if (v > 17'sd2047) begin
      sat12 = 12'sd2047;
    end else if (v < -17'sd2047) begin
      sat12 = -12'sd2047;
    end else begin
      sat12 = v[11:0];
    end
  endfunction

  function automatic logic [3:0] size_of(input logic signed [11:0] v);
    logic [11:0] mag;
    mag = v[11] ? (12'd0 - v) : v;
    size_of = 4'd0;
    for (int b = 0; b < 11; b++) begin
      if (mag[b]) size_of = 4'(b + 1);
    end
  endfunction

  // Negative values encode as (v-1) truncated to size bits (ones' complement of |v|).
  function automatic logic [10:0] amp_of(input logic signed [11:0] v, input logic [3:0] sz);
    logic [11:0] t;
    logic [11:0] mask;
    t      = v[11] ? (v - 12'sd1) : v;
    mask   = (12'd1 << sz) - 12'd1;
    amp_of = t[10:0] & mask[10:0];
  endfunction

  state_t             state_r;
  logic [5:0]         idx_r;
  logic [5:0]         run_r;
  logic               half_r;
  logic signed [11:0] pred_r;
  logic signed [11:0] coef_r;
  logic [4:0]         mem_adr_r;
  logic               sym_valid_r;
  logic [3:0]         sym_run_r;
  logic [3:0]         sym_size_r;
  logic [10:0]        sym_amp_r;
  logic               sym_dc_r;
  logic               sym_eob_r;
  logic               busy_r;
  logic               done_r;

  logic [15:0]        coef_raw_s;
  logic signed [11:0] c_sat_s;
  logic signed [16:0] diff_wide_s;
  logic signed [11:0] diff_s;
  logic signed [11:0] val_s;
  logic [3:0]         val_size_s;
  logic [10:0]        val_amp_s;
  logic [3:0]         d_size_s;
  logic [10:0]        d_amp_s;
  logic [5:0]         idx_next_s;
  logic [5:0]         zz_next_s;
  logic [5:0]         run_minus_s;

  assign coef_raw_s  = half_r ? bus.mem_dat[15:0] : bus.mem_dat[31:16];
  assign c_sat_s     = sat12({coef_raw_s[15], coef_raw_s});
  assign diff_wide_s = {{5{c_sat_s[11]}}, c_sat_s} - {{5{pred_r[11]}}, pred_r};
  assign diff_s      = sat12(diff_wide_s);
  assign idx_next_s  = idx_r + 6'd1;
  assign zz_next_s   = ZZ_TABLE[idx_next_s];
  assign run_minus_s = run_r - 6'd16;

  // Symbol field encoding; in ZRL the pending coefficient comes from coef_r.
  always_comb begin
    val_s = c_sat_s;
    if (state_r == ST_ZRL) begin
      val_s = coef_r;
    end else begin
      val_s = c_sat_s;
    end
    val_size_s = size_of(val_s);
    val_amp_s  = amp_of(val_s, val_size_s);
    d_size_s   = size_of(diff_s);
    d_amp_s    = amp_of(diff_s, d_size_s);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      idx_r       <= 6'd0;
      run_r       <= 6'd0;
      half_r      <= 1'b0;
      pred_r      <= 12'sd0;
      coef_r      <= 12'sd0;
      mem_adr_r   <= 5'd0;
      sym_valid_r <= 1'b0;
      sym_run_r   <= 4'd0;
      sym_size_r  <= 4'd0;
      sym_amp_r   <= 11'd0;
      sym_dc_r    <= 1'b0;
      sym_eob_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.clr_dc) pred_r <= 12'sd0;
          if (bus.start) begin
            idx_r     <= 6'd0;
            run_r     <= 6'd0;
            mem_adr_r <= ZZ_TABLE[0][5:1];
            half_r    <= ZZ_TABLE[0][0];
            busy_r    <= 1'b1;
            state_r   <= ST_FETCH;
          end
        end
        ST_FETCH: state_r <= ST_EVAL;
        ST_EVAL: begin
          coef_r <= c_sat_s;
          if (idx_r == 6'd0) begin
            pred_r      <= c_sat_s;
            sym_valid_r <= 1'b1;
            sym_run_r   <= 4'd0;
            sym_size_r  <= d_size_s;
            sym_amp_r   <= d_amp_s;
            sym_dc_r    <= 1'b1;
            sym_eob_r   <= 1'b0;
            state_r     <= ST_EMIT;
          end else if (c_sat_s == 12'sd0) begin
            run_r <= run_r + 6'd1;
            if (idx_r == 6'd63) begin
              sym_valid_r <= 1'b1;
              sym_run_r   <= 4'd0;
              sym_size_r  <= 4'd0;
              sym_amp_r   <= 11'd0;
              sym_dc_r    <= 1'b0;
              sym_eob_r   <= 1'b1;
              state_r     <= ST_EOB;
            end else begin
              idx_r     <= idx_next_s;
              mem_adr_r <= zz_next_s[5:1];
              half_r    <= zz_next_s[0];
              state_r   <= ST_FETCH;
            end
          end else if (run_r >= 6'd16) begin
            sym_valid_r <= 1'b1;
            sym_run_r   <= 4'd15;
            sym_size_r  <= 4'd0;
            sym_amp_r   <= 11'd0;
            sym_dc_r    <= 1'b0;
            sym_eob_r   <= 1'b0;
            state_r     <= ST_ZRL;
          end else begin
            sym_valid_r <= 1'b1;
            sym_run_r   <= run_r[3:0];
            sym_size_r  <= val_size_s;
            sym_amp_r   <= val_amp_s;
            sym_dc_r    <= 1'b0;
            sym_eob_r   <= 1'b0;
            run_r       <= 6'd0;
            state_r     <= ST_EMIT;
          end
        end
        ST_ZRL: begin
          if (bus.sym_ready) begin
            if (run_minus_s >= 6'd16) begin
              run_r <= run_minus_s;
            end else begin
              sym_run_r  <= run_minus_s[3:0];
              sym_size_r <= val_size_s;
              sym_amp_r  <= val_amp_s;
              run_r      <= 6'd0;
              state_r    <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (bus.sym_ready) begin
            sym_valid_r <= 1'b0;
            sym_run_r   <= 4'd0;
            sym_size_r  <= 4'd0;
            sym_amp_r   <= 11'd0;
            sym_dc_r    <= 1'b0;
            if (idx_r == 6'd63) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              idx_r     <= idx_next_s;
              mem_adr_r <= zz_next_s[5:1];
              half_r    <= zz_next_s[0];
              state_r   <= ST_FETCH;
            end
          end
        end
        ST_EOB: begin
          if (bus.sym_ready) begin
            sym_valid_r <= 1'b0;
            sym_eob_r   <= 1'b0;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_adr   = mem_adr_r;
  assign bus.sym_valid = sym_valid_r;
  assign bus.sym_run   = sym_run_r;
  assign bus.sym_size  = sym_size_r;
  assign bus.sym_amp   = sym_amp_r;
  assign bus.sym_dc    = sym_dc_r;
  assign bus.sym_eob   = sym_eob_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule
